// File: rtl/i2c_sniffer.sv
// i2c_sniffer: passive I2C decoder (START/STOP/byte/ACK) with event FIFO.
// Optional glitch filter: define I2C_SNIFFER_GLITCH_FILTER_EN.
module i2c_sniffer #(
  parameter int FIFO_AW    = 3,
  parameter int FILTER_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scl_i,
  input  logic               sda_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_kind,
  output logic [7:0]         out_data,
  output logic               out_ack,
  output logic [FIFO_AW:0]   level,
  output logic               overrun,
  input  logic               clr_overrun
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [1:0] K_START = 2'b01;
  localparam logic [1:0] K_STOP  = 2'b10;
  localparam logic [1:0] K_BYTE  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ACK  = 2'd2
  } state_t;

  logic scl_s1, scl_s2, sda_s1, sda_s2;
  logic scl_f, sda_f, scl_p, sda_p;
  logic armed;
  logic [1:0] settle;
  logic start_c, stop_c, bit_c;

  state_t state, state_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic [7:0] shift, shift_n;
  logic push;
  logic [10:0] push_ent;

  logic [10:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] count;
  logic full, pop, wr_en, drop;
  logic [10:0] head;

  // two-flop synchronizers, idle-high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
    end
  end

`ifdef I2C_SNIFFER_GLITCH_FILTER_EN
  localparam logic [3:0] FL_LAST = 4'(FILTER_LEN - 1);
  logic [3:0] scl_cnt, sda_cnt;

  // filtered line follows only after FILTER_LEN differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_s2 == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FL_LAST) begin
        scl_f   <= scl_s2;
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 4'd1;
      end
      if (sda_s2 == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FL_LAST) begin
        sda_f   <= sda_s2;
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 4'd1;
      end
    end
  end
`else
  logic unused_filter_len;
  assign unused_filter_len = ^FILTER_LEN;
  assign scl_f = scl_s2;
  assign sda_f = sda_s2;
`endif

  // previous levels and bus arming; the synchronizer reset value
  // is not a real observation, so arming waits for live samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_p  <= 1'b1;
      sda_p  <= 1'b1;
      armed  <= 1'b0;
      settle <= 2'd0;
    end else begin
      scl_p <= scl_f;
      sda_p <= sda_f;
      if (settle != 2'd2)
        settle <= settle + 2'd1;
      if (settle == 2'd2 && scl_f && sda_f && scl_s2 && sda_s2)
        armed <= 1'b1;
    end
  end

  assign start_c = armed & scl_p & scl_f & sda_p & ~sda_f;
  assign stop_c  = armed & scl_p & scl_f & ~sda_p & sda_f;
  assign bit_c   = ~scl_p & scl_f;

  // decoder state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      bitcnt <= 3'd0;
      shift  <= 8'd0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
      shift  <= shift_n;
    end
  end

  // decoder next state and event generation
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shift_n  = shift;
    push     = 1'b0;
    push_ent = 11'd0;
    if (!armed) begin
      state_n = IDLE;
    end else if (start_c) begin
      push     = 1'b1;
      push_ent = {K_START, 8'd0, 1'b0};
      state_n  = DATA;
      bitcnt_n = 3'd0;
      shift_n  = 8'd0;
    end else if (stop_c) begin
      push     = 1'b1;
      push_ent = {K_STOP, 8'd0, 1'b0};
      state_n  = IDLE;
    end else if (bit_c) begin
      unique case (state)
        IDLE: state_n = IDLE;
        DATA: begin
          shift_n  = {shift[6:0], sda_f};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7)
            state_n = ACK;
        end
        ACK: begin
          push     = 1'b1;
          push_ent = {K_BYTE, shift, ~sda_f};
          state_n  = DATA;
          bitcnt_n = 3'd0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign full  = (count == FULL_LVL);
  assign pop   = out_valid & out_ready;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // event storage
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= push_ent;
  end

  // FIFO pointers, occupancy and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign out_kind  = out_valid ? head[10:9] : 2'b00;
  assign out_data  = out_valid ? head[8:1] : 8'd0;
  assign out_ack   = out_valid ? head[0] : 1'b0;
  assign level     = count;

endmodule

// File: tb/tb_i2c_sniffer.sv
// tb_i2c_sniffer: scoreboard bench for the passive I2C sniffer.
// Build with I2C_SNIFFER_GLITCH_FILTER_EN to exercise the filter.
module tb_i2c_sniffer;

  localparam int Q = 60;
`ifdef I2C_SNIFFER_GLITCH_FILTER_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif
  localparam logic [10:0] EV_S = {2'b01, 8'h00, 1'b0};
  localparam logic [10:0] EV_P = {2'b10, 8'h00, 1'b0};

  logic clk = 1'b0;
  logic rst, scl, sda, out_ready, clr_overrun;
  logic out_valid, out_ack, overrun;
  logic [1:0] out_kind;
  logic [7:0] out_data;
  logic [3:0] level;

  logic [10:0] q[$];
  logic [10:0] exp;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  i2c_sniffer #(.FIFO_AW(3), .FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_data(out_data), .out_ack(out_ack),
    .level(level), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  function automatic logic [10:0] ev_b(logic [7:0] d, logic a);
    return {2'b11, d, a};
  endfunction

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda = 1'b1; cyc(Q);
    scl = 1'b1; cyc(Q);
    sda = 1'b0; cyc(Q);
    scl = 1'b0; cyc(Q);
  endtask

  task automatic bus_stop();
    sda = 1'b0; cyc(Q);
    scl = 1'b1; cyc(Q);
    sda = 1'b1; cyc(2 * Q);
  endtask

  task automatic bus_bit(logic b);
    sda = b;    cyc(Q);
    scl = 1'b1; cyc(2 * Q);
    scl = 1'b0; cyc(Q);
  endtask

  task automatic bus_byte(logic [7:0] d, logic ack);
    for (int i = 7; i >= 0; i--) bus_bit(d[i]);
    bus_bit(~ack);
  endtask

  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; sda = 1'b1;
    out_ready = 1'b0; clr_overrun = 1'b0;
    cyc(3);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_valid got %b want 0", out_valid);
    end
    compared++;
    if (level !== 4'd0) begin
      mismatched++;
      $display("FAIL rst_level got %0d want 0", level);
    end
    compared++;
    if (overrun !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_overrun got %b want 0", overrun);
    end
    compared++;
    if ({out_kind, out_data, out_ack} !== 11'd0) begin
      mismatched++;
      $display("FAIL rst_head got %h want 0", {out_kind, out_data, out_ack});
    end
    rst = 1'b0;
    cyc(10);
    compared++;
    if (level !== 4'd0) begin
      mismatched++;
      $display("FAIL idle_level got %0d want 0", level);
    end
  endtask

  task automatic test_write();
    q.push_back(EV_S);
    q.push_back(ev_b(8'hD0, 1'b1));
    q.push_back(ev_b(8'h00, 1'b1));
    q.push_back(EV_P);
    bus_start();
    bus_byte(8'hD0, 1'b1);
    bus_byte(8'h00, 1'b1);
    bus_stop();
    while (q.size() != 0) begin
      exp = q.pop_front();
      compared++;
      if (out_valid !== 1'b1 || {out_kind, out_data, out_ack} !== exp) begin
        mismatched++;
        $display("FAIL write_ev got v=%b %h want %h",
                 out_valid, {out_kind, out_data, out_ack}, exp);
      end
      out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    end
    compared++;
    if (level !== 4'd0) begin
      mismatched++;
      $display("FAIL write_empty got %0d want 0", level);
    end
  endtask

  task automatic test_read_rs();
    q.push_back(EV_S);
    q.push_back(ev_b(8'hA5, 1'b0));
    q.push_back(EV_S);
    q.push_back(EV_P);
    bus_start();
    bus_byte(8'hA5, 1'b0);
    bus_start();
    bus_stop();
    while (q.size() != 0) begin
      exp = q.pop_front();
      compared++;
      if (out_valid !== 1'b1 || {out_kind, out_data, out_ack} !== exp) begin
        mismatched++;
        $display("FAIL read_ev got v=%b %h want %h",
                 out_valid, {out_kind, out_data, out_ack}, exp);
      end
      out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        q.push_back(EV_S);
        q.push_back(EV_P);
      end
      sda = 1'b0; cyc(10);
      sda = 1'b1; cyc(10);
    end
    compared++;
    if (level !== 4'd8) begin
      mismatched++;
      $display("FAIL ovr_level got %0d want 8", level);
    end
    compared++;
    if (overrun !== 1'b1) begin
      mismatched++;
      $display("FAIL ovr_set got %b want 1", overrun);
    end
    clr_overrun = 1'b1; cyc(1); clr_overrun = 1'b0;
    compared++;
    if (overrun !== 1'b0) begin
      mismatched++;
      $display("FAIL ovr_clr got %b want 0", overrun);
    end
    while (q.size() != 0) begin
      exp = q.pop_front();
      compared++;
      if (out_valid !== 1'b1 || {out_kind, out_data, out_ack} !== exp) begin
        mismatched++;
        $display("FAIL ovr_ev got v=%b %h want %h",
                 out_valid, {out_kind, out_data, out_ack}, exp);
      end
      out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      q.push_back(EV_S);
      q.push_back(EV_P);
      sda = 1'b0; cyc(10);
      sda = 1'b1; cyc(10);
    end
    compared++;
    if (level !== 4'd8) begin
      mismatched++;
      $display("FAIL fpp_fill got %0d want 8", level);
    end
    sda = 1'b0;
    cyc(LAT - 1);
    exp = q.pop_front();
    compared++;
    if (out_valid !== 1'b1 || {out_kind, out_data, out_ack} !== exp) begin
      mismatched++;
      $display("FAIL fpp_head got v=%b %h want %h",
               out_valid, {out_kind, out_data, out_ack}, exp);
    end
    q.push_back(EV_S);
    out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    compared++;
    if (level !== 4'd8) begin
      mismatched++;
      $display("FAIL fpp_level got %0d want 8", level);
    end
    cyc(5);
    compared++;
    if (overrun !== 1'b0) begin
      mismatched++;
      $display("FAIL fpp_overrun got %b want 0", overrun);
    end
    while (q.size() != 0) begin
      exp = q.pop_front();
      compared++;
      if (out_valid !== 1'b1 || {out_kind, out_data, out_ack} !== exp) begin
        mismatched++;
        $display("FAIL fpp_ev got v=%b %h want %h",
                 out_valid, {out_kind, out_data, out_ack}, exp);
      end
      out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    end
    q.push_back(EV_P);
    sda = 1'b1; cyc(20);
    while (q.size() != 0) begin
      exp = q.pop_front();
      compared++;
      if (out_valid !== 1'b1 || {out_kind, out_data, out_ack} !== exp) begin
        mismatched++;
        $display("FAIL fpp_stop got v=%b %h want %h",
                 out_valid, {out_kind, out_data, out_ack}, exp);
      end
      out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    bus_start();
    bus_bit(1'b1);
    bus_bit(1'b0);
    bus_bit(1'b1);
    bus_bit(1'b1);
    sda = 1'b0;
    rst = 1'b1; cyc(2);
    scl = 1'b1; cyc(3);
    rst = 1'b0; cyc(30);
    compared++;
    if (out_valid !== 1'b0 || level !== 4'd0) begin
      mismatched++;
      $display("FAIL rmid_held got v=%b lvl=%0d want 0/0", out_valid, level);
    end
    sda = 1'b1; cyc(30);
    compared++;
    if (level !== 4'd0) begin
      mismatched++;
      $display("FAIL rmid_arm got %0d want 0", level);
    end
    q.push_back(EV_S);
    q.push_back(ev_b(8'h3C, 1'b1));
    q.push_back(EV_P);
    bus_start();
    bus_byte(8'h3C, 1'b1);
    bus_stop();
    while (q.size() != 0) begin
      exp = q.pop_front();
      compared++;
      if (out_valid !== 1'b1 || {out_kind, out_data, out_ack} !== exp) begin
        mismatched++;
        $display("FAIL rmid_ev got v=%b %h want %h",
                 out_valid, {out_kind, out_data, out_ack}, exp);
      end
      out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    end
  endtask

  task automatic test_glitch();
`ifndef I2C_SNIFFER_GLITCH_FILTER_EN
    q.push_back(EV_S);
    q.push_back(EV_P);
`endif
    sda = 1'b0; cyc(2);
    sda = 1'b1; cyc(20);
    q.push_back(EV_S);
    q.push_back(EV_P);
    sda = 1'b0; cyc(5);
    sda = 1'b1; cyc(20);
    while (q.size() != 0) begin
      exp = q.pop_front();
      compared++;
      if (out_valid !== 1'b1 || {out_kind, out_data, out_ack} !== exp) begin
        mismatched++;
        $display("FAIL glitch_ev got v=%b %h want %h",
                 out_valid, {out_kind, out_data, out_ack}, exp);
      end
      out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    end
    compared++;
    if (level !== 4'd0) begin
      mismatched++;
      $display("FAIL glitch_empty got %0d want 0", level);
    end
  endtask

  task automatic test_latency();
    sda = 1'b0;
    cyc(LAT - 1);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL lat_early got %b want 0", out_valid);
    end
    cyc(1);
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL lat_edge got %b want 1", out_valid);
    end
    q.push_back(EV_S);
    q.push_back(EV_P);
    cyc(10);
    sda = 1'b1; cyc(20);
    while (q.size() != 0) begin
      exp = q.pop_front();
      compared++;
      if (out_valid !== 1'b1 || {out_kind, out_data, out_ack} !== exp) begin
        mismatched++;
        $display("FAIL lat_ev got v=%b %h want %h",
                 out_valid, {out_kind, out_data, out_ack}, exp);
      end
      out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_rs();
    test_overrun();
    test_full_push_pop();
    test_reset_mid();
    test_glitch();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/i2c_sniffer.md
# i2c_sniffer

- Passive I2C bus decoder that sits downstream of the SDA/SCL bridge pair on the bridged RTC/tuner bus.
- Observes one SCL/SDA pair (typically the RTC-side pins), decodes START, STOP, data bytes and ACK/NACK, and queues decoded events in a small FIFO.
- A consumer (LED/debug logic or a UART dumper) drains the FIFO over valid/ready.
- Never drives the bus.

## Interface
Parameters:
- FIFO_AW, 3: FIFO address width; depth = 2^FIFO_AW entries of 11 bits.
- FILTER_LEN, 4: consecutive stable samples required before a filtered line changes. Used only with the glitch filter compiled in; legal range 1..15.

Ports:
- clk  in  1  system clock (24 MHz board clock)
- rst  in  1  asynchronous, active-high reset
- scl_i  in  1  raw SCL pin level, asynchronous
- sda_i  in  1  raw SDA pin level, asynchronous
- out_valid  out  1  FIFO non-empty; head event presented
- out_ready  in  1  consumer accepts head event
- out_kind  out  2  head event kind: 01 START, 10 STOP, 11 BYTE (00 never emitted)
- out_data  out  8  byte value for BYTE; 0 for START/STOP
- out_ack  out  1  1 = ACK (SDA low in 9th clock); 0 for NACK/START/STOP
- level  out  FIFO_AW+1  current FIFO occupancy
- overrun  out  1  sticky: an event was dropped because the FIFO was full
- clr_overrun  in  1  synchronous clear of overrun

## Operation
- Synchronizer: 2 flops per line, reset to 1.
- Filtered lines: scl_f and sda_f are either the synchronizer outputs directly or the glitch-filter outputs (see Configuration). Previous-value registers scl_p and sda_p reset to 1.
- Arming:
  - armed resets to 0.
  - armed sets when scl_f = sda_f = 1 in the same cycle.
  - While unarmed, no events are generated and the state machine stays IDLE.
- Conditions:
  - START: armed, scl_p=1, scl_f=1, sda_p=1, sda_f=0. A repeated START is reported identically.
  - STOP: armed, scl_p=1, scl_f=1, sda_p=0, sda_f=1.
  - Bit sample: scl_p=0, scl_f=1; the value taken is the current sda_f.
  - If SCL rises in the same cycle SDA changes, the cycle is a bit sample, never START/STOP.
- State machine (IDLE, DATA, ACK), with bitcnt 0..7 and an 8-bit shift register:
  - IDLE: START → push START; go DATA with bitcnt=0 and shift=0. Bit samples are ignored.
  - DATA: on a bit sample, shift ← {shift[6:0], sda_f} MSB first and bitcnt++. After the 8th bit, go ACK.
  - ACK: on a bit sample, push BYTE{data=shift, ack=~sda_f}; go DATA with bitcnt=0.
  - In DATA/ACK: START → push START and restart DATA; STOP → push STOP and go IDLE. Any partial byte is discarded with no BYTE event.
  - STOP in IDLE (after arming) → push STOP and stay IDLE.
- FIFO:
  - Show-ahead: out_* reflect the head entry whenever out_valid=1.
  - Pop on out_valid & out_ready.
  - Push accepted when not full, or when full with a pop in the same cycle.
  - A push rejected while full is dropped and sets overrun.
  - Same-cycle push and pop on empty FIFO: push accepted, pop does not occur (out_valid was 0).
  - Pointers wrap modulo 2^FIFO_AW. level is the exact count 0..2^FIFO_AW.
- overrun: set has priority over clr_overrun in the same cycle.
- Reset mid-transfer: FIFO emptied, state IDLE, armed=0, overrun=0. The partial transaction produces no events.

## Timing
- Reset values: out_valid=0, level=0, overrun=0. out_kind/out_data/out_ack=0.
- Latency, pin change to out_valid (empty FIFO):
  - Change captured by sync flop 1 at edge 0.
  - Without filter: sync flop 2 at edge 1, FIFO write at edge 2. out_valid high after edge 2 (3 cycles).
  - With filter: add FILTER_LEN cycles.
- out_valid drops the cycle after the popping edge if level becomes 0.
- One event at most per cycle; at most two events per SCL period. FIFO sizing is the consumer's responsibility.

## Configuration
- I2C_SNIFFER_GLITCH_FILTER_EN defined:
  - Each synchronized line has a 4-bit stability counter.
  - The filtered value takes the synchronized value only after it has differed from the filtered value for FILTER_LEN consecutive cycles.
  - The counter clears whenever the synchronized value equals the filtered value.
  - Pulses shorter than FILTER_LEN cycles are ignored.
- Macro undefined: scl_f/sda_f are the synchronizer outputs and FILTER_LEN is ignored.

## Test plan
- Write to 0x68 (START, byte 0xD0 ACK, byte 0x00 ACK, STOP) at 100 kHz → FIFO drains START, BYTE D0/ack1, BYTE 00/ack1, STOP.
- Read byte 0xA5 with master NACK, then repeated START and STOP → BYTE A5/ack0, START, STOP.
- out_ready=0 with FIFO_AW=3, 10 events generated → level=8, overrun=1, first 8 events retained. clr_overrun → overrun=0.
- Reset asserted after 4 data bits, SDA held low on release → no events until both lines are high. Then a full transfer decodes normally.
- With filter on (FILTER_LEN=4): 2-cycle SDA low glitch while SCL high → no START. 5-cycle pulse → START then STOP. With filter off, the 2-cycle glitch → START, STOP.
- Full FIFO with same-cycle push and pop → push accepted, level stays 8, overrun stays 0.
